// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad filter and its coefficient bank.
// Holds the coefficient address map, the bank FSM encoding and the reset
// coefficient constants, so the filter and the bank agree on them.
package biquad_pkg;

    // Default coefficient/data word width. It must match the filter's io_width.
    localparam int IO_WIDTH_DEF = 16;

    // Reset coefficients: b0 = 4096 with q = 14 gives unity gain.
    localparam int B0_RST_DEF = 4096;
    localparam int Q_RST_DEF  = 14;

    // Smallest legal q[3:0], equal to IO_WIDTH/2. It keeps the filter's
    // output shift (2*q - IO_WIDTH) from going negative.
    localparam int Q_MIN_DEF = 8;

    // Coefficient write addresses. Addresses 6 and 7 are invalid.
    localparam logic [2:0] ADDR_B0  = 3'd0;
    localparam logic [2:0] ADDR_B1  = 3'd1;
    localparam logic [2:0] ADDR_B2  = 3'd2;
    localparam logic [2:0] ADDR_Q   = 3'd3;
    localparam logic [2:0] ADDR_A1  = 3'd4;
    localparam logic [2:0] ADDR_A2  = 3'd5;
    localparam int         NUM_COEF = 6;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } bank_state_t;

endpackage

// File: rtl/biquad_coef_reg.sv
// One coefficient slot: a shadow register that the host writes, and an
// active register that drives the filter.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   wr, wr_data   load wr_data into the shadow register
//   load          copy the shadow register into the active register
//   shadow        current shadow value
//   active        current active value, wired toward the filter
module biquad_coef_reg #(
    parameter int                  WIDTH   = 16,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] active
);

    // NOTE: these are a handful of individual flops rather than a RAM, so they
    // take the reset directly. The filter needs known coefficients out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= RST_VAL;
            active <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make 'active' take the pre-edge
            // shadow value, even if 'shadow' is also written on this edge.
            if (wr) begin
                shadow <= wr_data;
            end
            if (load) begin
                active <= shadow;
            end
        end
    end

endmodule

// File: rtl/biquad_coef_bank.sv
// Coefficient bank in front of the biquad filter stage.
// The host writes a shadow set. A commit request is validated and then
// applied to the active set on the next filter sample strobe (en). The
// filter therefore never sees a mix of old and new coefficients.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data    single-cycle shadow write (addresses 0..5)
//   commit                     request to apply the shadow set
//   en                         filter sample strobe
//   busy                       commit accepted, waiting for en
//   commit_done                pulse: active set updated on the previous edge
//   commit_err                 pulse: commit rejected because q[3:0] < Q_MIN
//   wr_err                     pulse: write rejected (pending commit or bad address)
//   b0, b1, b2, q, a1, a2      active coefficients
module biquad_coef_bank
    import biquad_pkg::*;
#(
    parameter int IO_WIDTH = IO_WIDTH_DEF,
    parameter int B0_RST   = B0_RST_DEF,
    parameter int Q_RST    = Q_RST_DEF,
    parameter int Q_MIN    = Q_MIN_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [IO_WIDTH-1:0] wr_data,
    input  logic                commit,
    input  logic                en,
    output logic                busy,
    output logic                commit_done,
    output logic                commit_err,
    output logic                wr_err,
    output logic [IO_WIDTH-1:0] b0,
    output logic [IO_WIDTH-1:0] b1,
    output logic [IO_WIDTH-1:0] b2,
    output logic [IO_WIDTH-1:0] q,
    output logic [IO_WIDTH-1:0] a1,
    output logic [IO_WIDTH-1:0] a2
);

    bank_state_t         state, state_next;
    logic [IO_WIDTH-1:0] shadow [NUM_COEF];
    logic [IO_WIDTH-1:0] active [NUM_COEF];

    logic       wr_ok;
    logic       load;
    logic [3:0] q_lo_next;
    logic       q_legal;
    logic       commit_reject;

    // Writes are rejected while a commit is waiting. This freezes the set
    // that was validated.
    assign wr_ok = wr_en && (state == ST_IDLE) && (wr_addr <= ADDR_A2);
    assign load  = (state == ST_PENDING) && en;

    // Validation sees the shadow q as it will be after this edge. A write to q
    // in the same cycle as the commit therefore takes part in the check.
    assign q_lo_next = (wr_ok && (wr_addr == ADDR_Q)) ? wr_data[3:0] : shadow[ADDR_Q][3:0];
    assign q_legal   = (int'(q_lo_next) >= Q_MIN);
    assign commit_reject = (state == ST_IDLE) && commit && !q_legal;

    for (genvar i = 0; i < NUM_COEF; i++) begin : g_coef
        localparam logic [IO_WIDTH-1:0] RST_I =
            (i == int'(ADDR_B0)) ? IO_WIDTH'(B0_RST) :
            (i == int'(ADDR_Q))  ? IO_WIDTH'(Q_RST)  : '0;

        biquad_coef_reg #(
            .WIDTH   (IO_WIDTH),
            .RST_VAL (RST_I)
        ) u_reg (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_ok && (wr_addr == 3'(i))),
            .wr_data (wr_data),
            .load    (load),
            .shadow  (shadow[i]),
            .active  (active[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A commit that arrives together with en is applied on the following en,
    // because this cycle's en is seen while still in IDLE. Commits arriving in
    // PENDING are ignored.
    always_comb begin
        // NOTE: assigning the default first means every path drives state_next,
        // so no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE:    if (commit && q_legal) state_next = ST_PENDING;
            ST_PENDING: if (en)                state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            commit_done <= load;
            commit_err  <= commit_reject;
            wr_err      <= wr_en && !wr_ok;
        end
    end

    // busy is decoded straight from the state flop. It rises the cycle after an
    // accepted commit and falls in the same cycle that commit_done is high.
    assign busy = (state == ST_PENDING);

    assign b0 = active[ADDR_B0];
    assign b1 = active[ADDR_B1];
    assign b2 = active[ADDR_B2];
    assign q  = active[ADDR_Q];
    assign a1 = active[ADDR_A1];
    assign a2 = active[ADDR_A2];

endmodule

// File: tb/tb_biquad_coef_bank.sv
// Self-checking bench for biquad_coef_bank. A behavioural model holds the
// shadow and active coefficient arrays and a pending flag. Every DUT output
// is compared against that model one cycle after each stimulus edge.
module tb_biquad_coef_bank;
    import biquad_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         commit;
    logic         en;
    logic         busy, commit_done, commit_err, wr_err;
    logic [W-1:0] b0, b1, b2, q, a1, a2;

    biquad_coef_bank dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .en          (en),
        .busy        (busy),
        .commit_done (commit_done),
        .commit_err  (commit_err),
        .wr_err      (wr_err),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .q           (q),
        .a1          (a1),
        .a2          (a2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference model
    logic [W-1:0] m_sh  [6];
    logic [W-1:0] m_act [6];
    bit           m_pend, m_done, m_cerr, m_werr;

    function automatic logic [W-1:0] rst_val(input int i);
        if (i == 0) return 16'd4096;
        if (i == 3) return 16'd14;
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i]  = rst_val(i);
            m_act[i] = rst_val(i);
        end
        m_pend = 0;
        m_done = 0;
        m_cerr = 0;
        m_werr = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".b0"}, 32'(b0), 32'(m_act[0]));
        check({tag, ".b1"}, 32'(b1), 32'(m_act[1]));
        check({tag, ".b2"}, 32'(b2), 32'(m_act[2]));
        check({tag, ".q"},  32'(q),  32'(m_act[3]));
        check({tag, ".a1"}, 32'(a1), 32'(m_act[4]));
        check({tag, ".a2"}, 32'(a2), 32'(m_act[5]));
        check({tag, ".busy"},        32'(busy),        32'(m_pend));
        check({tag, ".commit_done"}, 32'(commit_done), 32'(m_done));
        check({tag, ".commit_err"},  32'(commit_err),  32'(m_cerr));
        check({tag, ".wr_err"},      32'(wr_err),      32'(m_werr));
    endtask

    // Apply one cycle of stimulus from a negedge, advance the model to its
    // post-edge state, then compare just after the rising edge.
    task automatic step(input string tag, input bit we, input int addr,
                        input logic [W-1:0] data, input bit cm, input bit e);
        bit wacc;
        wr_en   = we;
        wr_addr = 3'(addr);
        wr_data = data;
        commit  = cm;
        en      = e;

        wacc   = we && !m_pend && (addr <= 5);
        m_werr = we && !wacc;
        if (wacc) m_sh[addr] = data;
        m_done = m_pend && e;
        m_cerr = 0;
        if (m_pend) begin
            if (e) begin
                for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
                m_pend = 0;
            end
        end else if (cm) begin
            if (int'(m_sh[3][3:0]) >= 8) m_pend = 1;
            else                         m_cerr = 1;
        end

        @(posedge clk);
        #1;
        compare_all(tag);
        @(negedge clk);
        wr_en  = 0;
        commit = 0;
        en     = 0;
    endtask

    task automatic idle(input string tag, input int n, input bit e);
        for (int i = 0; i < n; i++) step(tag, 0, 0, '0, 0, e);
    endtask

    logic [W-1:0] neg3000;

    initial begin
        reset   = 1'b1;
        wr_en   = 0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 0;
        en      = 0;
        neg3000 = -16'sd3000;
        model_reset();
        #12;
        compare_all("reset");
        check("reset.b0_const", 32'(b0), 32'd4096);
        check("reset.q_const",  32'(q),  32'd14);
        @(negedge clk);
        reset = 1'b0;

        // 1: idle with en pulses, the reset coefficients stay in place
        idle("t1", 3, 1);

        // 2: b0=8192, q=13, commit, then a long wait with en low
        step("t2.wr_b0", 1, 0, 16'd8192, 0, 0);
        step("t2.wr_q",  1, 3, 16'd13,   0, 0);
        step("t2.commit", 0, 0, '0, 1, 0);
        idle("t2.hold", 10, 0);
        check("t2.busy_hold", 32'(busy), 32'd1);
        check("t2.b0_hold",   32'(b0),   32'd4096);
        step("t2.en", 0, 0, '0, 0, 1);
        check("t2.b0_new", 32'(b0), 32'd8192);
        check("t2.q_new",  32'(q),  32'd13);
        idle("t2.after", 2, 0);

        // 3: illegal q, the commit is rejected
        step("t3.wr_q", 1, 3, 16'd5, 0, 0);
        step("t3.commit", 0, 0, '0, 1, 0);
        idle("t3.en", 3, 1);
        check("t3.q_kept", 32'(q), 32'd13);

        // Boundary: q[3:0] = 7 is rejected, and upper q bits do not affect the check
        step("tb.wr_q7", 1, 3, 16'h00F7, 0, 0);
        step("tb.commit7", 0, 0, '0, 1, 0);
        // q = 8 is written on the same cycle as the commit and is accepted
        step("tb.wr_q8_commit", 1, 3, 16'h0108, 1, 0);
        step("tb.en", 0, 0, '0, 0, 1);
        check("tb.q_upper_kept", 32'(q), 32'h0108);

        // 4: write during PENDING is rejected; write to address 6 is rejected
        step("t4.wr_q", 1, 3, 16'd12, 0, 0);
        step("t4.commit", 0, 0, '0, 1, 0);
        step("t4.wr_b1_pend", 1, 1, 16'd123, 0, 0);
        step("t4.commit_again", 0, 0, '0, 1, 0);
        step("t4.en", 0, 0, '0, 0, 1);
        check("t4.b1_not_123", 32'(b1), 32'd0);
        step("t4.wr_addr6", 1, 6, 16'h7777, 0, 0);
        step("t4.wr_addr7", 1, 7, 16'h1234, 0, 1);

        // 5: write, commit and en on the same cycle
        step("t5.wr_commit_en", 1, 4, neg3000, 1, 1);
        check("t5.a1_not_yet", 32'(a1), 32'd0);
        idle("t5.wait", 2, 0);
        step("t5.en", 0, 0, '0, 0, 1);
        check("t5.a1_new", 32'(a1), 32'(neg3000));

        // 6: reset while a commit is pending
        step("t6.wr_b2", 1, 2, 16'd555, 0, 0);
        step("t6.commit", 0, 0, '0, 1, 0);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("t6.async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle("t6.after", 4, 1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit   we, cm, e;
            int   addr;
            we   = ($urandom_range(0, 99) < 40);
            cm   = ($urandom_range(0, 99) < 15);
            e    = ($urandom_range(0, 99) < 25);
            addr = $urandom_range(0, 7);
            step("rand", we, addr, W'($urandom), cm, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
